lua_fetch_decode: RTL and testbench

// - Nios II custom-instruction accelerator for the Lua 5.3 VM fetch/decode stage.
// - On start, through its Avalon-MM master: reads ci->u.l.savedpc, writes back savedpc+4,

---
 rtl/lua_fetch_decode_if.sv | 47 ++++
 rtl/lua_fetch_decode.sv | 155 +++++++++++++++
 tb/tb_lua_fetch_decode.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lua_fetch_decode_if.sv
// Bundles the Nios II custom-instruction slave, the Avalon-MM master and the
// decoded side-band fields of lua_fetch_decode into one port group.
interface lua_fetch_decode_if #(
  parameter int ADDR_W = 32
);
  logic [31:0]       nios_lua_exec_slave_dataa;
  logic [31:0]       nios_lua_exec_slave_datab;
  logic [1:0]        nios_lua_exec_slave_n;
  logic              nios_lua_exec_slave_clk_en;
  logic              nios_lua_exec_slave_start;
  logic              nios_lua_exec_slave_done;
  logic [31:0]       nios_lua_exec_slave_result;
  logic [ADDR_W-1:0] avalon_master_address;
  logic              avalon_master_read;
  logic              avalon_master_write;
  logic [31:0]       avalon_master_writedata;
  logic [31:0]       avalon_master_readdata;
  logic              avalon_master_waitrequest;
  logic              dec_valid;
  logic [5:0]        dec_op;
  logic [7:0]        dec_a;
  logic [8:0]        dec_c;
  logic [8:0]        dec_b;
  logic [31:0]       dec_sbx;

  // Accelerator side.
  modport master (
    input  nios_lua_exec_slave_dataa, nios_lua_exec_slave_datab, nios_lua_exec_slave_n,
           nios_lua_exec_slave_clk_en, nios_lua_exec_slave_start,
           avalon_master_readdata, avalon_master_waitrequest,
    output nios_lua_exec_slave_done, nios_lua_exec_slave_result,
           avalon_master_address, avalon_master_read, avalon_master_write,
           avalon_master_writedata,
           dec_valid, dec_op, dec_a, dec_c, dec_b, dec_sbx
  );

  // CPU and memory side.
  modport slave (
    output nios_lua_exec_slave_dataa, nios_lua_exec_slave_datab, nios_lua_exec_slave_n,
           nios_lua_exec_slave_clk_en, nios_lua_exec_slave_start,
           avalon_master_readdata, avalon_master_waitrequest,
    input  nios_lua_exec_slave_done, nios_lua_exec_slave_result,
           avalon_master_address, avalon_master_read, avalon_master_write,
           avalon_master_writedata,
           dec_valid, dec_op, dec_a, dec_c, dec_b, dec_sbx
  );
endinterface

// File: rtl/lua_fetch_decode.sv
// Lua 5.3 VM fetch/decode custom instruction: reads and bumps savedpc, fetches the
// instruction, reads base and returns the field chosen by n. LUA_FETCH_PERF_EN adds a stall counter.
module lua_fetch_decode #(
  parameter int ADDR_W         = 32,
  parameter int CI_BASE_OFS    = 16,
  parameter int CI_SAVEDPC_OFS = 20,
  parameter int TV_SHIFT       = 3,
  parameter int INSTR_BYTES    = 4
) (
  input  logic               clock_sink_clk,
  input  logic               reset_sink_reset,
  lua_fetch_decode_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_PC    = 3'd1,
    S_WR_PC    = 3'd2,
    S_RD_INSTR = 3'd3,
    S_RD_BASE  = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ci_q, pc_q, base_q;
  logic [31:0]       instr_q;
  logic [1:0]        n_q;

  logic [ADDR_W-1:0] addr_s;
  logic              rd_s, wr_s, done_s;
  logic [31:0]       wdata_s, result_s, perf_s;
  logic [ADDR_W-1:0] ra_s;

  assign ra_s = base_q + (ADDR_W'(instr_q[13:6]) << TV_SHIFT);

  // State register; clk_en gates every transition.
  always_ff @(posedge clock_sink_clk) begin
    if (reset_sink_reset) begin
      state_q <= S_IDLE;
    end else if (bus.nios_lua_exec_slave_clk_en) begin
      state_q <= state_d;
    end
  end

  // Latches ci/n at start and each word as its read completes.
  always_ff @(posedge clock_sink_clk) begin
    if (reset_sink_reset) begin
      ci_q    <= '0;
      n_q     <= 2'd0;
      pc_q    <= '0;
      instr_q <= 32'd0;
      base_q  <= '0;
    end else if (bus.nios_lua_exec_slave_clk_en) begin
      case (state_q)
        S_IDLE: if (bus.nios_lua_exec_slave_start) begin
          ci_q <= ADDR_W'(bus.nios_lua_exec_slave_datab);
          n_q  <= bus.nios_lua_exec_slave_n;
        end
        S_RD_PC:    if (!bus.avalon_master_waitrequest) pc_q    <= ADDR_W'(bus.avalon_master_readdata);
        S_RD_INSTR: if (!bus.avalon_master_waitrequest) instr_q <= bus.avalon_master_readdata;
        S_RD_BASE:  if (!bus.avalon_master_waitrequest) base_q  <= ADDR_W'(bus.avalon_master_readdata);
        default: ;
      endcase
    end
  end

`ifdef LUA_FETCH_PERF_EN
  logic [31:0] stall_q;

  // Saturating count of stalled bus cycles; an n=3 readout clears it.
  always_ff @(posedge clock_sink_clk) begin
    if (reset_sink_reset) begin
      stall_q <= 32'd0;
    end else if (bus.nios_lua_exec_slave_clk_en) begin
      if (state_q == S_DONE && n_q == 2'd3) begin
        stall_q <= 32'd0;
      end else if ((rd_s | wr_s) && bus.avalon_master_waitrequest && stall_q != 32'hFFFF_FFFF) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end
  assign perf_s = stall_q;
`else
  assign perf_s = 32'd0;
`endif

  // Next state plus bus strobes and result, all decoded from the current state.
  always_comb begin
    state_d  = state_q;
    addr_s   = '0;
    rd_s     = 1'b0;
    wr_s     = 1'b0;
    wdata_s  = 32'd0;
    done_s   = 1'b0;
    result_s = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (bus.nios_lua_exec_slave_start) state_d = S_RD_PC;
        else state_d = S_IDLE;
      end
      S_RD_PC: begin
        addr_s = ci_q + ADDR_W'(CI_SAVEDPC_OFS);
        rd_s   = 1'b1;
        if (!bus.avalon_master_waitrequest) state_d = S_WR_PC;
        else state_d = S_RD_PC;
      end
      S_WR_PC: begin
        addr_s  = ci_q + ADDR_W'(CI_SAVEDPC_OFS);
        wr_s    = 1'b1;
        wdata_s = 32'(pc_q + ADDR_W'(INSTR_BYTES));
        if (!bus.avalon_master_waitrequest) state_d = S_RD_INSTR;
        else state_d = S_WR_PC;
      end
      S_RD_INSTR: begin
        addr_s = pc_q;
        rd_s   = 1'b1;
        if (!bus.avalon_master_waitrequest) state_d = S_RD_BASE;
        else state_d = S_RD_INSTR;
      end
      S_RD_BASE: begin
        addr_s = ci_q + ADDR_W'(CI_BASE_OFS);
        rd_s   = 1'b1;
        if (!bus.avalon_master_waitrequest) state_d = S_DONE;
        else state_d = S_RD_BASE;
      end
      S_DONE: begin
        done_s  = 1'b1;
        state_d = S_IDLE;
        case (n_q)
          2'd0:    result_s = instr_q;
          2'd1:    result_s = 32'(ra_s);
          2'd2:    result_s = 32'(pc_q);
          default: result_s = perf_s;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.avalon_master_address      = addr_s;
  assign bus.avalon_master_read         = rd_s;
  assign bus.avalon_master_write        = wr_s;
  assign bus.avalon_master_writedata    = wdata_s;
  assign bus.nios_lua_exec_slave_done   = done_s;
  assign bus.nios_lua_exec_slave_result = result_s;

  // Decoded fields are forced to zero except in the completion cycle.
  assign bus.dec_valid = done_s;
  assign bus.dec_op    = done_s ? instr_q[5:0]   : 6'd0;
  assign bus.dec_a     = done_s ? instr_q[13:6]  : 8'd0;
  assign bus.dec_c     = done_s ? instr_q[22:14] : 9'd0;
  assign bus.dec_b     = done_s ? instr_q[31:23] : 9'd0;
  assign bus.dec_sbx   = done_s ? ({14'd0, instr_q[31:14]} - 32'd131071) : 32'd0;

endmodule

// File: tb/tb_lua_fetch_decode.sv
// Directed bench for lua_fetch_decode: small CallInfo/memory model, scripted stalls,
// clk_en freezes and resets, hand-computed results.
module tb_lua_fetch_decode;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lua_fetch_decode_if bus ();

  lua_fetch_decode dut (
    .clock_sink_clk   (clk),
    .reset_sink_reset (rst),
    .bus              (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_ci, mem_pc, mem_instr, mem_base;
  logic [31:0] wr_addr, wr_data;

  // Memory model: savedpc at ci+20, base at ci+16, instruction at pc.
  always_comb begin
    if (bus.avalon_master_address == mem_ci + 32'd20)      bus.avalon_master_readdata = mem_pc;
    else if (bus.avalon_master_address == mem_ci + 32'd16) bus.avalon_master_readdata = mem_base;
    else if (bus.avalon_master_address == mem_pc)          bus.avalon_master_readdata = mem_instr;
    else                                                   bus.avalon_master_readdata = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (bus.avalon_master_write && !bus.avalon_master_waitrequest) begin
      wr_addr <= bus.avalon_master_address;
      wr_data <= bus.avalon_master_writedata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  logic [31:0] res;
  int lat;
  logic [5:0]  d_op;
  logic [7:0]  d_a;
  logic [8:0]  d_c, d_b;
  logic [31:0] d_sbx;
  logic        d_valid;

  // Cycle 0 carries start; waitrequest high in cycles [st_from, st_from+st_len),
  // clk_en low in cycles [fz_from, fz_from+fz_len).
  task automatic run_op(input logic [1:0] n, input int st_from, input int st_len,
                        input int fz_from, input int fz_len);
    lat = 0;
    res = 32'hX;
    @(negedge clk);
    bus.nios_lua_exec_slave_datab  = mem_ci;
    bus.nios_lua_exec_slave_dataa  = 32'h0BAD_F00D;
    bus.nios_lua_exec_slave_n      = n;
    bus.nios_lua_exec_slave_start  = 1'b1;
    bus.avalon_master_waitrequest  = 1'b0;
    bus.nios_lua_exec_slave_clk_en = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus.nios_lua_exec_slave_start  = 1'b0;
      bus.avalon_master_waitrequest  = (k >= st_from) && (k < st_from + st_len);
      bus.nios_lua_exec_slave_clk_en = !((k >= fz_from) && (k < fz_from + fz_len));
      if (bus.avalon_master_waitrequest) begin
        check("stall_addr", bus.avalon_master_address, mem_pc);
        check("stall_read", {31'd0, bus.avalon_master_read}, 32'd1);
      end
      if (!bus.nios_lua_exec_slave_clk_en) begin
        check("frz_addr", bus.avalon_master_address, mem_ci + 32'd20);
        check("frz_read", {31'd0, bus.avalon_master_read}, 32'd1);
      end
      if (bus.nios_lua_exec_slave_done) begin
        lat = k;
        res = bus.nios_lua_exec_slave_result;
        d_valid = bus.dec_valid;
        d_op = bus.dec_op; d_a = bus.dec_a; d_c = bus.dec_c; d_b = bus.dec_b;
        d_sbx = bus.dec_sbx;
        break;
      end
    end
    bus.avalon_master_waitrequest  = 1'b0;
    bus.nios_lua_exec_slave_clk_en = 1'b1;
    if (lat == 0) check("timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("done_pulse", {31'd0, bus.nios_lua_exec_slave_done}, 32'd0);
    check("res_idle", bus.nios_lua_exec_slave_result, 32'd0);
  endtask

  initial begin
    bus.nios_lua_exec_slave_dataa  = 32'd0;
    bus.nios_lua_exec_slave_datab  = 32'd0;
    bus.nios_lua_exec_slave_n      = 2'd0;
    bus.nios_lua_exec_slave_start  = 1'b0;
    bus.nios_lua_exec_slave_clk_en = 1'b1;
    bus.avalon_master_waitrequest  = 1'b0;
    mem_ci = 32'h0000_1000; mem_pc = 32'h0000_2000;
    mem_instr = 32'h0001_C0C5; mem_base = 32'h0000_3000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", {31'd0, bus.nios_lua_exec_slave_done}, 32'd0);
    check("rst_read", {31'd0, bus.avalon_master_read}, 32'd0);
    check("rst_write", {31'd0, bus.avalon_master_write}, 32'd0);
    check("rst_result", bus.nios_lua_exec_slave_result, 32'd0);
    check("rst_sbx", bus.dec_sbx, 32'd0);
    rst = 1'b0;

    // n=0, no stalls: instruction, pc bump and decoded fields.
    run_op(2'd0, 0, 0, 0, 0);
    check("n0_result", res, 32'h0001_C0C5);
    check("n0_latency", lat, 32'd5);
    check("n0_wr_addr", wr_addr, 32'h0000_1014);
    check("n0_wr_data", wr_data, 32'h0000_2004);
    check("dec_valid", {31'd0, d_valid}, 32'd1);
    check("dec_op", {26'd0, d_op}, 32'd5);
    check("dec_a", {24'd0, d_a}, 32'd3);
    check("dec_c", {23'd0, d_c}, 32'd7);
    check("dec_b", {23'd0, d_b}, 32'd0);
    check("dec_sbx", d_sbx, 32'hFFFE_0008);

    run_op(2'd1, 0, 0, 0, 0);
    check("n1_ra", res, 32'h0000_3018);
    run_op(2'd2, 0, 0, 0, 0);
    check("n2_pc", res, 32'h0000_2000);

    // Three waitrequest cycles while fetching the instruction.
    run_op(2'd0, 3, 3, 0, 0);
    check("stall_latency", lat, 32'd8);
    check("stall_result", res, 32'h0001_C0C5);

    // clk_en low for two cycles in RD_PC.
    run_op(2'd2, 0, 0, 1, 2);
    check("frz_latency", lat, 32'd7);
    check("frz_result", res, 32'h0000_2000);

    // pc at the top of the address space wraps on increment.
    mem_pc = 32'hFFFF_FFFC;
    run_op(2'd2, 0, 0, 0, 0);
    check("wrap_wr_data", wr_data, 32'h0000_0000);
    check("wrap_pc", res, 32'hFFFF_FFFC);
    mem_pc = 32'h0000_2000;

    // Reset while writing savedpc back.
    @(negedge clk);
    bus.nios_lua_exec_slave_datab = mem_ci;
    bus.nios_lua_exec_slave_n     = 2'd0;
    bus.nios_lua_exec_slave_start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.nios_lua_exec_slave_start = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid_write", {31'd0, bus.avalon_master_write}, 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("mrst_read", {31'd0, bus.avalon_master_read}, 32'd0);
    check("mrst_write", {31'd0, bus.avalon_master_write}, 32'd0);
    check("mrst_done", {31'd0, bus.nios_lua_exec_slave_done}, 32'd0);
    rst = 1'b0;
    run_op(2'd1, 0, 0, 0, 0);
    check("post_rst_ra", res, 32'h0000_3018);
    check("post_rst_latency", lat, 32'd5);

    // Stall counter readout: counted stalls, then cleared.
    run_op(2'd3, 3, 3, 0, 0);
`ifdef LUA_FETCH_PERF_EN
    check("perf_count", res, 32'd3);
`else
    check("perf_count", res, 32'd0);
`endif
    run_op(2'd3, 0, 0, 0, 0);
    check("perf_cleared", res, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
